// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Hardwired control unit for the DataPath. It sequences the instruction fetch
// (T0-T2) and the register-to-register ALU execute phase (T3-T5). It also
// handles a memory-ready wait state in T1, run/pause control, NOP, HALT, a
// sticky illegal-opcode flag and a retired-instruction counter.
//
// Ports
//   clock        system clock, rising edge
//   clear        synchronous active-high reset
//   run          continue to the next instruction (sampled leaving IDLE/T3/T5)
//   mem_ready    memory read complete (sampled in T1)
//   ir           latched instruction register from DataPath (valid from T3)
//   PCout..Yin   DataPath control strobes
//   R_in/R_out   one-hot register load / bus-drive enables (R0..R15)
//   alu_op       ALU operation, valid in T4 only, 0 otherwise
//   halted       high while in HALT
//   illegal      sticky undefined-opcode flag
//   instr_count  retired instruction count, wraps modulo 2^CNTW
// ---------------------------------------------------------------------------
module instr_sequencer #(
   parameter int unsigned OPW  = 5,
   parameter int unsigned CNTW = 16
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            run,
   input  logic            mem_ready,
   input  logic [31:0]     ir,
   output logic            PCout,
   output logic            MARin,
   output logic            IncPC,
   output logic            Zlowin,
   output logic            Zlowout,
   output logic            PCin,
   output logic            Read,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            Yin,
   output logic [15:0]     R_in,
   output logic [15:0]     R_out,
   output logic [OPW-1:0]  alu_op,
   output logic            halted,
   output logic            illegal,
   output logic [CNTW-1:0] instr_count
);

   // State encoding
   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StT0   = 3'd1;
   localparam logic [2:0] StT1   = 3'd2;
   localparam logic [2:0] StT2   = 3'd3;
   localparam logic [2:0] StT3   = 3'd4;
   localparam logic [2:0] StT4   = 3'd5;
   localparam logic [2:0] StT5   = 3'd6;
   localparam logic [2:0] StHalt = 3'd7;

   // Opcodes. ALU opcodes occupy the contiguous range add..rol.
   localparam logic [OPW-1:0] OpRol  = OPW'(8);
   localparam logic [OPW-1:0] OpNop  = OPW'(26);
   localparam logic [OPW-1:0] OpHalt = OPW'(27);

   logic [2:0]      state_q, state_d;
   logic            illegal_q, illegal_d;
   logic [CNTW-1:0] count_q, count_d;

   // Instruction fields
   logic [OPW-1:0] opc;
   logic [3:0]     ra, rb, rc;
   logic           is_alu, is_nop, is_halt;
   logic           unused_ir;

   assign opc       = ir[31 -: OPW];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];

   assign is_alu  = (opc <= OpRol);
   assign is_nop  = (opc == OpNop);
   assign is_halt = (opc == OpHalt);

   // Next-state, sticky flag and counter
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      count_d   = count_q;
      case (state_q)
         StIdle: begin
            if (run) state_d = StT0;
         end
         StT0: state_d = StT1;
         StT1: begin
            // Waiting here just repeats an idempotent PC reload from Z.
            if (mem_ready) state_d = StT2;
         end
         StT2: state_d = StT3;
         StT3: begin
            if (is_alu) begin
               state_d = StT4;
            end else if (is_halt) begin
               count_d = count_q + CNTW'(1);
               state_d = StHalt;
            end else begin
               // NOP retires; undefined opcodes behave as NOP but do not retire.
               if (is_nop) count_d = count_q + CNTW'(1);
               else        illegal_d = 1'b1;
               state_d = run ? StT0 : StIdle;
            end
         end
         StT4: state_d = StT5;
         StT5: begin
            count_d = count_q + CNTW'(1);
            state_d = run ? StT0 : StIdle;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q   <= StIdle;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   // Moore strobe decode. Exactly one bus driver per cycle at most:
   // PCout (T0), Zlowout (T1/T5), MDRout (T2), R_out (T3/T4).
   always_comb begin
      PCout   = 1'b0;
      MARin   = 1'b0;
      IncPC   = 1'b0;
      Zlowin  = 1'b0;
      Zlowout = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      R_in    = 16'h0000;
      R_out   = 16'h0000;
      alu_op  = '0;
      case (state_q)
         StT0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
         end
         StT1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         StT2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         StT3: begin
            if (is_alu) begin
               R_out = 16'h0001 << rb;
               Yin   = 1'b1;
            end
         end
         StT4: begin
            R_out  = 16'h0001 << rc;
            Zlowin = 1'b1;
            alu_op = opc;
         end
         StT5: begin
            Zlowout = 1'b1;
            R_in    = 16'h0001 << ra;
         end
         default: ;
      endcase
   end

   assign halted      = (state_q == StHalt);
   assign illegal     = illegal_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Self-checking bench: a table of directed ALU instructions checked phase by
// phase, hand-written multi-cycle sequences (reset mid-instruction, memory
// wait states, halt, illegal opcode, run drop), then randomised instruction
// streams compared against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

   logic        clock = 1'b0;
   logic        clear, run, mem_ready;
   logic [31:0] ir;
   logic        PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin;
   logic [15:0] R_in, R_out;
   logic [4:0]  alu_op;
   logic        halted, illegal;
   logic [15:0] instr_count;

   instr_sequencer #(.OPW(5), .CNTW(16)) dut (
      .clock       (clock),
      .clear       (clear),
      .run         (run),
      .mem_ready   (mem_ready),
      .ir          (ir),
      .PCout       (PCout),
      .MARin       (MARin),
      .IncPC       (IncPC),
      .Zlowin      (Zlowin),
      .Zlowout     (Zlowout),
      .PCin        (PCin),
      .Read        (Read),
      .MDRin       (MDRin),
      .MDRout      (MDRout),
      .IRin        (IRin),
      .Yin         (Yin),
      .R_in        (R_in),
      .R_out       (R_out),
      .alu_op      (alu_op),
      .halted      (halted),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   always #5 clock = ~clock;

   logic [10:0] strobes;
   assign strobes = {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin};

   // Expected strobe sets, bit order as in 'strobes'
   localparam logic [10:0] StbNone = 11'b00000000000;
   localparam logic [10:0] StbT0   = 11'b11110000000;
   localparam logic [10:0] StbT1   = 11'b00001111000;
   localparam logic [10:0] StbT2   = 11'b00000000110;
   localparam logic [10:0] StbT3   = 11'b00000000001;
   localparam logic [10:0] StbT4   = 11'b00010000000;
   localparam logic [10:0] StbT5   = 11'b00001000000;

   localparam int NumRand = 150;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      return {opc, ra, rb, rc, 15'h0000};
   endfunction

   task automatic check_all_zero(input string name);
      check({name, " strobes"}, 32'(strobes), 32'(StbNone));
      check({name, " R_in"}, 32'(R_in), 32'h0);
      check({name, " R_out"}, 32'(R_out), 32'h0);
      check({name, " alu_op"}, 32'(alu_op), 32'h0);
      check({name, " halted"}, 32'(halted), 32'h0);
      check({name, " illegal"}, 32'(illegal), 32'h0);
      check({name, " count"}, 32'(instr_count), 32'h0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   typedef struct {
      logic [31:0] ir;
      logic [15:0] rout3;
      logic [15:0] rout4;
      logic [4:0]  op;
      logic [15:0] rin5;
   } vec_t;

   vec_t tbl[5];

   // Random-phase bookkeeping
   logic [4:0]  cur_opc;
   logic [3:0]  cur_ra, cur_rb, cur_rc;
   int          cur_w, reads_seen, cyc, rout_n, rin_n, n_done, guard;
   logic [15:0] rout_v0, rout_v1, rin_v;
   logic [4:0]  aluop_v;
   logic        in_instr;
   int          exp_count;
   logic        exp_illegal;

   initial begin
      int bad;
      int r;
      int drv;
      logic is_alu, is_nop;

      tbl[0] = '{mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 16'h0004, 16'h0008, 5'b00011, 16'h0002};
      tbl[1] = '{mk_ir(5'b00000, 4'd15, 4'd0, 4'd7), 16'h0001, 16'h0080, 5'b00000, 16'h8000};
      tbl[2] = '{mk_ir(5'b00001, 4'd0, 4'd15, 4'd15), 16'h8000, 16'h8000, 5'b00001, 16'h0001};
      tbl[3] = '{mk_ir(5'b01000, 4'd5, 4'd9, 4'd10), 16'h0200, 16'h0400, 5'b01000, 16'h0020};
      tbl[4] = '{mk_ir(5'b00101, 4'd7, 4'd3, 4'd1), 16'h0008, 16'h0002, 5'b00101, 16'h0080};

      clear     = 1'b1;
      run       = 1'b0;
      mem_ready = 1'b1;
      ir        = 32'h0;
      step();
      step();
      check_all_zero("reset");
      clear = 1'b0;

      // Directed ALU vectors, back to back from IDLE
      for (int i = 0; i < 5; i++) begin
         ir  = tbl[i].ir;
         run = 1'b1;
         step();
         check("vec T0 strobes", 32'(strobes), 32'(StbT0));
         step();
         check("vec T1 strobes", 32'(strobes), 32'(StbT1));
         step();
         check("vec T2 strobes", 32'(strobes), 32'(StbT2));
         step();
         check("vec T3 strobes", 32'(strobes), 32'(StbT3));
         check("vec T3 R_out", 32'(R_out), 32'(tbl[i].rout3));
         check("vec T3 alu_op", 32'(alu_op), 32'h0);
         step();
         check("vec T4 strobes", 32'(strobes), 32'(StbT4));
         check("vec T4 R_out", 32'(R_out), 32'(tbl[i].rout4));
         check("vec T4 alu_op", 32'(alu_op), 32'(tbl[i].op));
         step();
         check("vec T5 strobes", 32'(strobes), 32'(StbT5));
         check("vec T5 R_in", 32'(R_in), 32'(tbl[i].rin5));
         check("vec T5 R_out", 32'(R_out), 32'h0);
         run = 1'b0;
         step();
         check("vec idle strobes", 32'(strobes), 32'(StbNone));
         check("vec count", 32'(instr_count), 32'(i + 1));
      end

      // Reset during T4 of an ALU instruction
      ir  = tbl[0].ir;
      run = 1'b1;
      for (int k = 0; k < 5; k++) step();
      check("pre-reset T4 R_out", 32'(R_out), 32'h0008);
      clear = 1'b1;
      run   = 1'b0;
      step();
      check_all_zero("reset in T4");
      clear = 1'b0;

      // Memory wait states: 3 cycles of mem_ready=0 in T1
      mem_ready = 1'b0;
      ir        = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
      run       = 1'b1;
      step();
      check("wait T0 strobes", 32'(strobes), 32'(StbT0));
      for (int k = 0; k < 4; k++) begin
         step();
         check("wait T1 strobes", 32'(strobes), 32'(StbT1));
         if (k == 3) mem_ready = 1'b1;
      end
      step();
      check("wait T2 strobes", 32'(strobes), 32'(StbT2));
      step();
      step();
      step();
      check("wait T5 R_in", 32'(R_in), 32'h0002);
      run = 1'b0;
      step();
      check("wait count", 32'(instr_count), 32'h1);

      // HALT: holds with run=1 until clear
      do_clear();
      ir  = mk_ir(5'b11011, 4'd3, 4'd4, 4'd5);
      run = 1'b1;
      step();
      step();
      step();
      step();
      check("halt T3 strobes", 32'(strobes), 32'(StbNone));
      check("halt T3 R_out", 32'(R_out), 32'h0);
      check("halt T3 halted", 32'(halted), 32'h0);
      step();
      check("halt halted", 32'(halted), 32'h1);
      check("halt count", 32'(instr_count), 32'h1);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (halted !== 1'b1 || strobes !== StbNone || R_in !== 16'h0 || R_out !== 16'h0) bad++;
      end
      check("halt hold bad cycles", 32'(bad), 32'h0);
      run   = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("halt cleared", 32'(halted), 32'h0);
      check("halt cleared count", 32'(instr_count), 32'h0);
      step();
      check("halt idle strobes", 32'(strobes), 32'(StbNone));

      // Illegal opcode, then an add still executes
      ir  = mk_ir(5'b10101, 4'd1, 4'd2, 4'd3);
      run = 1'b1;
      step();
      step();
      step();
      step();
      check("illegal T3 strobes", 32'(strobes), 32'(StbNone));
      check("illegal T3 R_out", 32'(R_out), 32'h0);
      step();
      check("illegal next T0", 32'(strobes), 32'(StbT0));
      check("illegal flag", 32'(illegal), 32'h1);
      check("illegal count", 32'(instr_count), 32'h0);
      ir = mk_ir(5'b00000, 4'd4, 4'd5, 4'd6);
      step();
      step();
      step();
      check("post-illegal T3 R_out", 32'(R_out), 32'h0020);
      step();
      check("post-illegal T4 R_out", 32'(R_out), 32'h0040);
      step();
      check("post-illegal T5 R_in", 32'(R_in), 32'h0010);
      run = 1'b0;
      step();
      check("post-illegal count", 32'(instr_count), 32'h1);
      check("post-illegal sticky", 32'(illegal), 32'h1);

      // run dropped in T4
      do_clear();
      ir  = mk_ir(5'b00001, 4'd2, 4'd3, 4'd4);
      run = 1'b1;
      for (int k = 0; k < 5; k++) step();
      run = 1'b0;
      step();
      check("rundrop T5 strobes", 32'(strobes), 32'(StbT5));
      step();
      check("rundrop idle 1", 32'(strobes), 32'(StbNone));
      step();
      check("rundrop idle 2", 32'(strobes), 32'(StbNone));
      check("rundrop count", 32'(instr_count), 32'h1);
      run = 1'b1;
      step();
      check("rundrop restart T0", 32'(strobes), 32'(StbT0));

      // Randomised instruction stream vs instruction-level model
      clear = 1'b1;
      run   = 1'b0;
      step();
      clear       = 1'b0;
      run         = 1'b1;
      exp_count   = 0;
      exp_illegal = 1'b0;
      in_instr    = 1'b0;
      n_done      = 0;
      guard       = 0;
      cyc         = 0;
      while (n_done < NumRand && guard < 20000) begin
         step();
         guard++;
         drv = int'(PCout) + int'(Zlowout) + int'(MDRout) + int'(R_out != 16'h0);
         check("rand bus/onehot", {29'h0, drv <= 1, $onehot0(R_out), $onehot0(R_in)}, 32'h7);
         if (PCout) begin
            if (in_instr) begin
               is_alu = (cur_opc <= 5'd8);
               is_nop = (cur_opc == 5'd26);
               if (is_alu || is_nop) exp_count++;
               else                  exp_illegal = 1'b1;
               check("rand latency", 32'(cyc), 32'((is_alu ? 6 : 4) + cur_w));
               check("rand count", 32'(instr_count), 32'(exp_count[15:0]));
               check("rand illegal", 32'(illegal), 32'(exp_illegal));
               if (is_alu) begin
                  check("rand rout events", 32'(rout_n), 32'h2);
                  check("rand rout rb", 32'(rout_v0), 32'h1 << cur_rb);
                  check("rand rout rc", 32'(rout_v1), 32'h1 << cur_rc);
                  check("rand rin ra", 32'(rin_v), 32'h1 << cur_ra);
                  check("rand alu_op", 32'(aluop_v), 32'(cur_opc));
               end else begin
                  check("rand no reg traffic", 32'(rout_n + rin_n), 32'h0);
               end
            end
            r = $urandom_range(0, 99);
            if (r < 70) begin
               cur_opc = 5'($urandom_range(0, 8));
            end else if (r < 85) begin
               cur_opc = 5'd26;
            end else begin
               do cur_opc = 5'($urandom_range(9, 31));
               while (cur_opc == 5'd26 || cur_opc == 5'd27);
            end
            cur_ra     = 4'($urandom_range(0, 15));
            cur_rb     = 4'($urandom_range(0, 15));
            cur_rc     = 4'($urandom_range(0, 15));
            cur_w      = $urandom_range(0, 3);
            ir         = mk_ir(cur_opc, cur_ra, cur_rb, cur_rc);
            reads_seen = 0;
            cyc        = 0;
            rout_n     = 0;
            rin_n      = 0;
            rout_v0    = 16'h0;
            rout_v1    = 16'h0;
            rin_v      = 16'h0;
            aluop_v    = 5'h0;
            in_instr   = 1'b1;
            n_done++;
         end
         if (in_instr) cyc++;
         if (Read) begin
            reads_seen++;
            mem_ready = (reads_seen > cur_w);
         end
         if (R_out != 16'h0) begin
            if (rout_n == 0) rout_v0 = R_out;
            if (rout_n == 1) begin
               rout_v1 = R_out;
               aluop_v = alu_op;
            end
            rout_n++;
         end
         if (R_in != 16'h0) begin
            rin_v = R_in;
            rin_n++;
         end
      end
      check("rand completed", 32'(n_done >= NumRand), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
